// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared types and default widths for the ADC conversion sequencer
package adc_seq_pkg;
  localparam int NUM_CHANNELS_DEF = 16;
  localparam int CHANNEL_WIDTH_DEF = $clog2(NUM_CHANNELS_DEF);
  localparam int DATA_WIDTH_DEF = 12;
  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, OUTPUT} seq_state_t;
  typedef struct packed {
    logic [CHANNEL_WIDTH_DEF-1:0] channel;
    logic [DATA_WIDTH_DEF-1:0] data;
    logic timeout;
  } adc_sample_t;
endpackage

// File: rtl/adc_conversion_sequencer_pending.sv
// adc_pending_tracker: per-channel pending/overrun request flags
// Ports: channel_trigger sets pending; clr/clr_idx clears one channel on accept;
// channel_ready = pending, channel_urgent = overrun (both registered).
module adc_pending_tracker #(
  parameter int NUM_CHANNELS = 16,
  parameter int CHANNEL_WIDTH = $clog2(NUM_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CHANNELS-1:0]  channel_trigger,
  input  logic                     clr,
  input  logic [CHANNEL_WIDTH-1:0] clr_idx,
  output logic [NUM_CHANNELS-1:0]  channel_ready,
  output logic [NUM_CHANNELS-1:0]  channel_urgent
);
  logic [NUM_CHANNELS-1:0] clr_vec;
  assign clr_vec = clr ? (NUM_CHANNELS'(1) << clr_idx) : '0;
  // A trigger landing on the channel being cleared restarts its request cleanly:
  // pending stays set and no overrun is flagged.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      channel_ready <= '0;
      channel_urgent <= '0;
    end else begin
      channel_ready <= channel_trigger | (channel_ready & ~clr_vec);
      channel_urgent <= ~clr_vec & (channel_urgent | (channel_trigger & channel_ready));
    end
endmodule

// File: rtl/adc_conversion_sequencer.sv
// adc_conversion_sequencer: accepts arbiter grants, runs mux/settle/start/done, emits tagged samples
// Ports: channel_trigger -> channel_ready/channel_urgent (request tracking);
// selected_channel/channel_valid -> channel_accept, adc_busy (grant handshake);
// adc_ch_sel/adc_start/adc_done/adc_data (ADC front end);
// out_valid/out_ready/out_channel/out_data/out_timeout (sample port); conv_count (handshakes).
// Optional: define ADC_SEQ_TIMEOUT_EN to abort a conversion after TIMEOUT_CYCLES.
module adc_conversion_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int CHANNEL_WIDTH = $clog2(NUM_CHANNELS),
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CHANNELS-1:0]  channel_trigger,
  output logic [NUM_CHANNELS-1:0]  channel_ready,
  output logic [NUM_CHANNELS-1:0]  channel_urgent,
  input  logic [CHANNEL_WIDTH-1:0] selected_channel,
  input  logic                     channel_valid,
  output logic                     channel_accept,
  output logic                     adc_busy,
  output logic [CHANNEL_WIDTH-1:0] adc_ch_sel,
  output logic                     adc_start,
  input  logic                     adc_done,
  input  logic [DATA_WIDTH-1:0]    adc_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHANNEL_WIDTH-1:0] out_channel,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_timeout,
  output logic [15:0]              conv_count
);
  localparam int SW = $clog2(SETTLE_CYCLES + 2);
  seq_state_t state, state_nx;
  logic [SW-1:0] settle_cnt;
  logic capture, expire;
  // adc_start is high only in the first CONVERT cycle, so it doubles as the
  // "ignore done in the start cycle" qualifier.
  assign capture = (state == CONVERT) && !adc_start && adc_done;
`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd_cnt <= '0;
    else wd_cnt <= (state == CONVERT) ? wd_cnt + 1'b1 : '0;
  assign expire = (state == CONVERT) && (int'(wd_cnt) == TIMEOUT_CYCLES - 1);
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    channel_accept = 1'b0;
    unique case (state)
      IDLE: begin
        channel_accept = channel_valid;
        state_nx = channel_valid ? (SETTLE_CYCLES == 0 ? CONVERT : SETTLE) : IDLE;
      end
      SETTLE: state_nx = (int'(settle_cnt) == SETTLE_CYCLES - 1) ? CONVERT : SETTLE;
      CONVERT: state_nx = (capture || expire) ? OUTPUT : CONVERT;
      OUTPUT: state_nx = out_ready ? IDLE : OUTPUT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      adc_busy <= 1'b0;
      adc_start <= 1'b0;
      out_valid <= 1'b0;
      settle_cnt <= '0;
      adc_ch_sel <= '0;
      out_channel <= '0;
      out_data <= '0;
      out_timeout <= 1'b0;
      conv_count <= '0;
    end else begin
      state <= state_nx;
      adc_busy <= state_nx != IDLE;
      adc_start <= (state_nx == CONVERT) && (state != CONVERT);
      out_valid <= state_nx == OUTPUT;
      settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
      if (channel_accept) adc_ch_sel <= selected_channel;
      // A done strobe coincident with watchdog expiry yields a normal sample.
      if (capture || expire) begin
        out_channel <= adc_ch_sel;
        out_data <= capture ? adc_data : '0;
        out_timeout <= !capture;
      end
      if (out_valid && out_ready && conv_count != '1) conv_count <= conv_count + 1'b1;
    end
  adc_pending_tracker #(.NUM_CHANNELS(NUM_CHANNELS), .CHANNEL_WIDTH(CHANNEL_WIDTH)) u_pending (
    .clk(clk),
    .rst_n(rst_n),
    .channel_trigger(channel_trigger),
    .clr(channel_accept),
    .clr_idx(selected_channel),
    .channel_ready(channel_ready),
    .channel_urgent(channel_urgent)
  );
endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// tb_adc_conversion_sequencer: model-checked bench for the ADC conversion sequencer
module tb_adc_conversion_sequencer;
  import adc_seq_pkg::*;
  localparam int NC = 16, CW = 4, DW = 12, S = 4, TO = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [NC-1:0] trig, rdy, urg;
  logic [CW-1:0] sel, ch_sel, och;
  logic cv, acc, busy, start, done, ov, ordy, oto;
  logic [DW-1:0] data, odat;
  logic [15:0] cnt;
  logic [NC-1:0] z_rdy, z_urg;
  logic [CW-1:0] z_sel, z_ch_sel, z_och;
  logic z_cv, z_acc, z_busy, z_start, z_done, z_ov, z_ordy, z_oto;
  logic [DW-1:0] z_data, z_odat;
  logic [15:0] z_cnt;
  adc_conversion_sequencer #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .channel_trigger(trig), .channel_ready(rdy), .channel_urgent(urg),
    .selected_channel(sel), .channel_valid(cv), .channel_accept(acc), .adc_busy(busy),
    .adc_ch_sel(ch_sel), .adc_start(start), .adc_done(done), .adc_data(data),
    .out_valid(ov), .out_ready(ordy), .out_channel(och), .out_data(odat), .out_timeout(oto),
    .conv_count(cnt));
  adc_conversion_sequencer #(.SETTLE_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut0 (
    .clk(clk), .rst_n(rst_n), .channel_trigger('0), .channel_ready(z_rdy), .channel_urgent(z_urg),
    .selected_channel(z_sel), .channel_valid(z_cv), .channel_accept(z_acc), .adc_busy(z_busy),
    .adc_ch_sel(z_ch_sel), .adc_start(z_start), .adc_done(z_done), .adc_data(z_data),
    .out_valid(z_ov), .out_ready(z_ordy), .out_channel(z_och), .out_data(z_odat), .out_timeout(z_oto),
    .conv_count(z_cnt));
  int n_chk = 0, n_fail = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Behavioural model: n counts clock edges; a grant accepted at edge e puts the
  // start cycle right after edge e+S, done counts from edge start+2, and the
  // watchdog fires at edge start+TO.
  int n = 0, m_start = -100, m_sel = 0, m_och = 0, m_dat = 0, m_cnt = 0;
  bit m_busy = 0, m_ov = 0, m_oto = 0;
  bit [NC-1:0] m_pend = '0, m_ovr = '0;
  wire m_acc = !m_busy && cv;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy <= 0; m_ov <= 0; m_oto <= 0; m_pend <= '0; m_ovr <= '0;
      m_sel <= 0; m_och <= 0; m_dat <= 0; m_start <= -100; m_cnt <= 0;
    end else begin
      n <= n + 1;
      for (int i = 0; i < NC; i++) begin
        m_pend[i] <= trig[i] || (m_pend[i] && !(m_acc && int'(sel) == i));
        m_ovr[i] <= !(m_acc && int'(sel) == i) && (m_ovr[i] || (trig[i] && m_pend[i]));
      end
      if (m_acc) begin
        m_busy <= 1; m_sel <= int'(sel); m_start <= n + 1 + S;
      end else if (m_busy && !m_ov) begin
        if (n + 1 >= m_start + 2 && done) begin
          m_ov <= 1; m_och <= m_sel; m_dat <= int'(data); m_oto <= 0;
        end
`ifdef ADC_SEQ_TIMEOUT_EN
        else if (n + 1 >= m_start + TO) begin
          m_ov <= 1; m_och <= m_sel; m_dat <= 0; m_oto <= 1;
        end
`endif
      end else if (m_ov && ordy) begin
        m_ov <= 0; m_busy <= 0;
        if (m_cnt < 65535) m_cnt <= m_cnt + 1;
      end
    end
  bit chk_en = 0;
  always @(negedge clk)
    if (chk_en) begin
      chk("ready", 32'(rdy), 32'(m_pend));
      chk("urgent", 32'(urg), 32'(m_ovr));
      chk("accept", 32'(acc), 32'(m_acc));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("ch_sel", 32'(ch_sel), 32'(m_sel));
      chk("start", 32'(start), 32'(m_busy && !m_ov && n == m_start));
      chk("out_valid", 32'(ov), 32'(m_ov));
      chk("conv_count", 32'(cnt), 32'(m_cnt));
      if (m_ov) begin
        chk("out_channel", 32'(och), 32'(m_och));
        chk("out_data", 32'(odat), 32'(m_dat));
        chk("out_timeout", 32'(oto), 32'(m_oto));
      end
    end
  // ADC stand-in: done pulses lat cycles after the start cycle; lat < 0 never answers.
  int lat = 10;
  logic [DW-1:0] adc_val = '0;
  initial begin
    done = 0; data = '0;
    forever begin
      tick;
      if (start && lat >= 0) begin
        repeat (lat) tick;
        done = 1; data = adc_val;
        tick;
        done = 0;
      end
    end
  end
  task automatic grant(input int ch);
    cv = 1; sel = CW'(ch);
    tick;
    cv = 0;
  endtask
  task automatic wait_ov;
    for (int k = 0; k < 100 && !ov; k++) tick;
    chk("wait_out_valid", 32'(ov), 32'd1);
  endtask
  task automatic wait_idle;
    for (int k = 0; k < 100 && busy; k++) tick;
    chk("wait_idle", 32'(busy), 32'd0);
  endtask
  adc_sample_t got;
  int acc_n, st_n;
  logic [DW-1:0] held;
  initial begin
    trig = '0; sel = '0; cv = 0; ordy = 1;
    z_sel = '0; z_cv = 0; z_done = 0; z_data = '0; z_ordy = 1;
    repeat (3) tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_outs", 32'({och, odat, oto, ch_sel}), 32'd0);
    chk("rst_conv_count", 32'(cnt), 32'd0);
    chk("rst_flags", {rdy, urg}, 32'd0);
    rst_n = 1; chk_en = 1;
    tick;
    // ch3 trigger, grant, ADC answers 10 cycles after start
    adc_val = 12'hABC; lat = 10;
    trig[3] = 1; tick; trig = '0;
    chk("t1_ready3", 32'(rdy[3]), 32'd1);
    cv = 1; sel = 4'd3;
    @(negedge clk);
    chk("t1_accept", 32'(acc), 32'd1);
    acc_n = n;
    tick; cv = 0;
    chk("t1_ready3_clr", 32'(rdy[3]), 32'd0);
    for (int k = 0; k < 50 && !start; k++) tick;
    chk("t1_start_latency", n - acc_n, 32'd5);
    st_n = n;
    wait_ov;
    chk("t1_done_latency", n - st_n, 32'd11);
    got = {och, odat, oto};
    chk("t1_sample", 32'(got), 32'({4'd3, 12'hABC, 1'b0}));
    tick;
    chk("t1_conv_count", 32'(cnt), 32'd1);
    // back-pressure: out_ready low for 20 cycles while arbiter keeps valid high
    ordy = 0; adc_val = 12'h123; lat = 2;
    cv = 1; sel = 4'd7;
    tick;
    wait_ov;
    held = odat;
    repeat (20) tick;
    chk("t2_hold_valid", 32'(ov), 32'd1);
    chk("t2_hold_data", 32'(odat), 32'(held));
    chk("t2_hold_tag", 32'({och, odat}), 32'({4'd7, 12'h123}));
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_no_accept", 32'(acc), 32'd0);
    cv = 0; ordy = 1;
    tick;
    chk("t2_conv_count", 32'(cnt), 32'd2);
    wait_idle;
    // overrun on ch5, then trigger coincident with its accept
    trig[5] = 1; tick; trig = '0; tick;
    trig[5] = 1; tick; trig = '0;
    chk("t3_urgent5", 32'(urg[5]), 32'd1);
    adc_val = 12'h555; lat = 1;
    trig[5] = 1; cv = 1; sel = 4'd5;
    tick;
    trig = '0; cv = 0;
    chk("t3_ready5_kept", 32'(rdy[5]), 32'd1);
    chk("t3_urgent5_clr", 32'(urg[5]), 32'd0);
    wait_ov;
    tick;
    wait_idle;
    // zero-settle instance: start right after accept, done in start cycle ignored
    z_cv = 1; z_sel = 4'd9;
    @(negedge clk);
    chk("t4_accept", 32'(z_acc), 32'd1);
    tick; z_cv = 0;
    chk("t4_start", 32'(z_start), 32'd1);
    chk("t4_busy", 32'(z_busy), 32'd1);
    z_done = 1; z_data = 12'h111;
    tick; z_done = 0;
    chk("t4_start_done_ignored", 32'(z_ov), 32'd0);
    chk("t4_start_once", 32'(z_start), 32'd0);
    tick;
    z_done = 1; z_data = 12'h222;
    tick; z_done = 0;
    chk("t4_sample", 32'({z_ov, z_och, z_odat, z_oto}), 32'({1'b1, 4'd9, 12'h222, 1'b0}));
    tick;
    chk("t4_handshake", 32'({z_ov, z_busy, z_cnt}), 32'({1'b0, 1'b0, 16'd1}));
`ifdef ADC_SEQ_TIMEOUT_EN
    // watchdog: no done at all
    lat = -1;
    grant(2);
    for (int k = 0; k < 50 && !start; k++) tick;
    st_n = n;
    wait_ov;
    chk("t5_timeout_latency", n - st_n, 32'd15);
    chk("t5_timeout_sample", 32'({och, odat, oto}), 32'({4'd2, 12'h000, 1'b1}));
    tick;
    wait_idle;
`endif
    // done coincident with watchdog expiry (plain late done without the watchdog)
    lat = TO - 1; adc_val = 12'h5A5;
    grant(4);
    for (int k = 0; k < 50 && !start; k++) tick;
    st_n = n;
    wait_ov;
    chk("t5_coincident_latency", n - st_n, 32'd15);
    chk("t5_coincident_sample", 32'({och, odat, oto}), 32'({4'd4, 12'h5A5, 1'b0}));
    tick;
    wait_idle;
    // asynchronous reset in the middle of CONVERT
    lat = -1;
    grant(6);
    for (int k = 0; k < 50 && !start; k++) tick;
    chk("t6_in_convert", 32'(start), 32'd1);
    tick; tick;
    rst_n = 0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_start_ov", 32'({start, ov}), 32'd0);
    chk("t6_rst_regs", 32'({ch_sel, och, odat, oto}), 32'd0);
    chk("t6_rst_count", 32'(cnt), 32'd0);
    chk("t6_rst_flags", {rdy, urg}, 32'd0);
    tick;
    rst_n = 1;
    tick;
    lat = 3; adc_val = 12'h0F0;
    grant(8);
    wait_ov;
    chk("t6_after_reset", 32'({och, odat, oto}), 32'({4'd8, 12'h0F0, 1'b0}));
    tick;
    chk("t6_count", 32'(cnt), 32'd1);
    wait_idle;
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/adc_conversion_sequencer.md
# adc_conversion_sequencer

Consumer end of the channel arbiter handshake: accepts the granted channel (`selected_channel`/`channel_valid`), returns `channel_accept`, and reports `adc_busy` for the whole conversion. It runs the ADC front-end sequence: mux select, settle, start pulse and wait for done. It then presents one tagged sample downstream on a valid/ready port. It also generates the arbiter's per-channel `channel_ready`/`channel_urgent` inputs from trigger requests.

## Interface
- NUM_CHANNELS, 16, channel count; must match the arbiter
- CHANNEL_WIDTH, $clog2(NUM_CHANNELS), channel index width
- DATA_WIDTH, 12, ADC result width
- SETTLE_CYCLES, 4, mux settle cycles before start; 0 allowed
- TIMEOUT_CYCLES, 1023, CONVERT cycles before abort; used only with the timeout macro
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- channel_trigger  in  NUM_CHANNELS  per-channel one-cycle sample request
- channel_ready  out  NUM_CHANNELS  pending request per channel
- channel_urgent  out  NUM_CHANNELS  overrun: request arrived while already pending
- selected_channel  in  CHANNEL_WIDTH  arbiter grant
- channel_valid  in  1  grant valid
- channel_accept  out  1  grant taken this cycle
- adc_busy  out  1  sequencer not IDLE
- adc_ch_sel  out  CHANNEL_WIDTH  ADC mux select
- adc_start  out  1  one-cycle conversion start
- adc_done  in  1  conversion complete strobe
- adc_data  in  DATA_WIDTH  result, valid with adc_done
- out_valid  out  1  sample available
- out_ready  in  1  downstream accepts
- out_channel  out  CHANNEL_WIDTH  sample channel tag
- out_data  out  DATA_WIDTH  sample value
- out_timeout  out  1  sample aborted by timeout (0 when the timeout macro is off)
- conv_count  out  16  completed handshakes, saturating at 16'hFFFF

## Operation
- States: IDLE, SETTLE, CONVERT, OUTPUT.
- IDLE:
  - `channel_accept = channel_valid` (combinational, IDLE only).
  - On accept: latch `selected_channel` into `adc_ch_sel`, clear that channel's pending and overrun bits.
  - Go to SETTLE, or to CONVERT when SETTLE_CYCLES = 0.
- SETTLE: count SETTLE_CYCLES cycles, then go to CONVERT.
- CONVERT:
  - `adc_start = 1` in the first cycle only.
  - `adc_done` is ignored in the start cycle.
  - First `adc_done` after the start cycle: capture `adc_data` into `out_data`, then go to OUTPUT.
- OUTPUT:
  - `out_valid = 1`; outputs held stable until `out_ready`.
  - On handshake: `conv_count` += 1 (saturating), go to IDLE.
- `adc_busy` = (state != IDLE), registered. It is therefore low in every IDLE cycle, which the arbiter needs to raise `channel_valid`.
- Pending per channel:
  - `channel_trigger[i]` sets `pending[i]`.
  - Trigger while `pending[i]` is set and not being cleared that cycle sets `overrun[i]`.
- Trigger and accept-clear on the same channel in the same cycle: pending stays 1, overrun stays 0.
- `channel_ready = pending`, `channel_urgent = overrun`; both registered.
- A grant for a channel with pending = 0 is still accepted and converted; the sequencer trusts the arbiter.

## Timing
- Reset values:
  - state IDLE.
  - `adc_busy`, `adc_start`, `out_valid`, `out_timeout` all 0.
  - `adc_ch_sel`, `out_channel`, `out_data`, `conv_count` all 0.
  - `channel_ready`, `channel_urgent` all 0.
- Reset mid-conversion: immediate return to IDLE, `adc_start` drops, any pending sample and flags are lost.
- Accept cycle T:
  - `adc_busy` = 1 at T+1.
  - `adc_start` at T+1+SETTLE_CYCLES.
- `adc_done` at cycle D: `out_valid` at D+1.
  - Zero-stall total: accept to `out_valid` = SETTLE_CYCLES + 1 + (ADC latency) + 1.
- Handshake at cycle H: IDLE at H+1, so the next accept is possible at H+1.
  - Minimum grant spacing: SETTLE_CYCLES + 4 cycles.
- `adc_done` outside CONVERT is ignored.

## Configuration
- `ADC_SEQ_TIMEOUT_EN` defined:
  - A CONVERT watchdog counts cycles from the start cycle.
  - After TIMEOUT_CYCLES cycles without `adc_done`, go to OUTPUT with `out_data = 0`, `out_timeout = 1`.
  - `adc_done` in the same cycle as expiry wins: normal sample, `out_timeout = 0`.
- Not defined: CONVERT waits indefinitely, `out_timeout` tied 0, no counter logic.

## Structure
- Package `adc_seq_pkg`:
  - `seq_state_t` enum.
  - `adc_sample_t` struct: channel, data, timeout.
  - Default width localparams.
- Sub-module `adc_pending_tracker`:
  - Owns the pending/overrun vectors.
  - Inputs: `channel_trigger`, clear strobe, clear index.
  - Outputs: `channel_ready`, `channel_urgent`.

## Test plan
- Trigger ch3, arbiter grants 3 with SETTLE_CYCLES = 4, ADC done 10 cycles after start, `adc_data` = 12'hABC, `out_ready` = 1 → `adc_start` exactly 5 cycles after accept; sample {ch3, 12'hABC} out; `channel_ready[3]` clears on accept; `conv_count` = 1.
- `out_ready` held 0 for 20 cycles → `out_valid` and sample held stable, `adc_busy` = 1, `channel_accept` = 0 despite `channel_valid`.
- Trigger ch5 twice while pending → `channel_urgent[5]` = 1. Trigger ch5 in the same cycle as its accept → `channel_ready[5]` = 1, `channel_urgent[5]` = 0.
- SETTLE_CYCLES = 0 → `adc_start` in the cycle after accept. `adc_done` asserted in the start cycle → ignored; the next done is captured.
- `ADC_SEQ_TIMEOUT_EN` on, TIMEOUT_CYCLES = 15, no `adc_done` → `out_valid` with `out_timeout` = 1, `out_data` = 0. Done coincident with expiry → normal sample, `out_timeout` = 0.
- `rst_n` asserted during CONVERT → all outputs at reset values asynchronously; after release, a new grant is accepted normally.
